// File: rtl/dm_bridge.sv
// dm_bridge: stalls the core while one data load/store runs over a req/ack memory bus
module dm_bridge #(
  parameter int TIMEOUT   = 255,
  parameter int WORD_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [WORD_SIZE-1:0] i_addr,
  input  logic [WORD_SIZE-1:0] i_wd,
  input  logic [3:0]           i_wen,
  input  logic                 i_ren,
  output logic [WORD_SIZE-1:0] o_rd,
  output logic                 o_stall,
  output logic                 o_fault,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [3:0]           o_mem_be,
  output logic [WORD_SIZE-1:0] o_mem_addr,
  output logic [WORD_SIZE-1:0] o_mem_wdata,
  input  logic                 i_mem_ack,
  input  logic [WORD_SIZE-1:0] i_mem_rdata,
  input  logic                 i_mem_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state_q, state_d;
  logic [WORD_SIZE-1:0] rd_q, rd_d, addr_q, addr_d, wd_q, wd_d;
  logic [3:0] be_q, be_d;
  logic we_q, we_d, fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic access, expired;
  assign access  = i_ren || (i_wen != 4'h0);
  assign expired = cnt_q == CW'(TIMEOUT - 1);
  // accept in IDLE, wait for ack or timeout in REQ, retire for one cycle in DONE
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    we_d    = we_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (access) begin
        state_d = REQ;
        addr_d  = i_addr;
        wd_d    = i_wd;
        we_d    = i_wen != 4'h0;
        be_d    = (i_wen != 4'h0) ? i_wen : 4'hF;
        cnt_d   = '0;
        fault_d = 1'b0;
      end
      REQ: if (i_mem_ack) begin
        state_d = DONE;
        fault_d = i_mem_err;
        rd_d    = we_q ? rd_q : (i_mem_err ? '0 : i_mem_rdata);
      end else if (expired) begin
        state_d = DONE;
        fault_d = 1'b1;
        rd_d    = we_q ? rd_q : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rd_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      we_q    <= we_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end
  assign o_rd        = rd_q;
  assign o_stall     = (state_q == IDLE || i_rst) ? access : state_q == REQ;
  assign o_fault     = state_q == DONE && fault_q;
  assign o_mem_req   = state_q == REQ;
  assign o_mem_we    = we_q;
  assign o_mem_be    = be_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wd_q;
endmodule

// File: tb/tb_dm_bridge.sv
// tb_dm_bridge: table-driven and random transaction checks of dm_bridge against a transaction-level model
module tb_dm_bridge;
  localparam int TO = 4;
  logic i_clk = 1'b0, i_rst = 1'b1;
  logic [31:0] i_addr = '0, i_wd = '0, i_mem_rdata = '0;
  logic [3:0] i_wen = '0;
  logic i_ren = 1'b0, i_mem_ack = 1'b0, i_mem_err = 1'b0;
  logic [31:0] o_rd, o_mem_addr, o_mem_wdata;
  logic o_stall, o_fault, o_mem_req, o_mem_we;
  logic [3:0] o_mem_be;
  int checks = 0, errors = 0;
  logic [31:0] rd_model = '0;

  typedef struct {
    logic        ren;
    logic [3:0]  wen;
    logic [31:0] addr, wd;
    int          wait_n;
    logic        ack, err;
    logic [31:0] rdata, exp_rd;
    logic        exp_fault;
    int          exp_reqs;
  } vec_t;

  dm_bridge #(.TIMEOUT(TO), .WORD_SIZE(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_wd(i_wd), .i_wen(i_wen),
    .i_ren(i_ren), .o_rd(o_rd), .o_stall(o_stall), .o_fault(o_fault),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .i_mem_err(i_mem_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t mk(input logic ren, input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wd, input int wait_n, input logic ack,
                              input logic err, input logic [31:0] rdata, input logic [31:0] exp_rd,
                              input logic exp_fault, input int exp_reqs);
    vec_t v;
    v.ren = ren; v.wen = wen; v.addr = addr; v.wd = wd; v.wait_n = wait_n;
    v.ack = ack; v.err = err; v.rdata = rdata; v.exp_rd = exp_rd;
    v.exp_fault = exp_fault; v.exp_reqs = exp_reqs;
    return v;
  endfunction

  // Transaction-level reference: an ack arriving before the timeout budget ends the access,
  // otherwise the bus is held for exactly TO cycles and the access faults.
  function automatic vec_t model(input vec_t v, input logic [31:0] rd_prev);
    bit acked;
    acked = v.ack && v.wait_n < TO;
    v.exp_reqs  = acked ? v.wait_n + 1 : TO;
    v.exp_fault = !acked || v.err;
    v.exp_rd    = (v.wen != 4'h0) ? rd_prev : ((acked && !v.err) ? v.rdata : 32'h0);
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    logic we;
    logic [3:0] be;
    we = v.wen != 4'h0;
    be = we ? v.wen : 4'hF;
    i_ren = v.ren; i_wen = v.wen; i_addr = v.addr; i_wd = v.wd; i_mem_ack = 1'b0;
    #1;
    check("idle_stall", 32'(o_stall), 32'd1);
    check("idle_req", 32'(o_mem_req), 32'd0);
    check("idle_fault", 32'(o_fault), 32'd0);
    for (int k = 0; k < v.exp_reqs; k++) begin
      step();
      i_mem_ack   = v.ack && k == v.wait_n;
      i_mem_rdata = i_mem_ack ? v.rdata : $urandom;
      i_mem_err   = i_mem_ack ? v.err : 1'($urandom);
      #1;
      check("req_valid", 32'(o_mem_req), 32'd1);
      check("req_stall", 32'(o_stall), 32'd1);
      check("req_fault", 32'(o_fault), 32'd0);
      check("req_we", 32'(o_mem_we), 32'(we));
      check("req_be", 32'(o_mem_be), 32'(be));
      check("req_addr", o_mem_addr, v.addr);
      check("req_wdata", o_mem_wdata, v.wd);
    end
    step();
    i_mem_ack = 1'b1; i_mem_rdata = $urandom; i_mem_err = 1'b0;
    #1;
    check("done_req", 32'(o_mem_req), 32'd0);
    check("done_stall", 32'(o_stall), 32'd0);
    check("done_fault", 32'(o_fault), 32'(v.exp_fault));
    check("done_rd", o_rd, v.exp_rd);
    step();
    i_ren = 1'b0; i_wen = 4'h0; i_mem_ack = 1'b0;
    #1;
    check("post_req", 32'(o_mem_req), 32'd0);
    check("post_stall", 32'(o_stall), 32'd0);
    check("post_fault", 32'(o_fault), 32'd0);
    check("post_rd", o_rd, v.exp_rd);
  endtask

  initial begin
    vec_t tbl[9];
    vec_t v;
    tbl[0] = mk(1, 4'h0, 32'h100, 32'h0,        0, 1, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1);
    tbl[1] = mk(0, 4'hF, 32'h204, 32'h12345678, 3, 1, 0, 32'h0BADBAD0, 32'hCAFEF00D, 0, 4);
    tbl[2] = mk(1, 4'h0, 32'h108, 32'h0,        0, 0, 0, 32'h0,        32'h0,        1, 4);
    tbl[3] = mk(1, 4'h0, 32'h040, 32'h0,        1, 1, 0, 32'h11223344, 32'h11223344, 0, 2);
    tbl[4] = mk(1, 4'h0, 32'h044, 32'h0,        0, 1, 1, 32'hFFFFFFFF, 32'h0,        1, 1);
    tbl[5] = mk(1, 4'h0, 32'h080, 32'h0,        2, 1, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 3);
    tbl[6] = mk(1, 4'h3, 32'h300, 32'hDEADBEEF, 0, 1, 0, 32'h55555555, 32'hA5A5A5A5, 0, 1);
    tbl[7] = mk(0, 4'h1, 32'h304, 32'h000000AA, 0, 0, 0, 32'h0,        32'hA5A5A5A5, 1, 4);
    tbl[8] = mk(0, 4'hC, 32'h308, 32'hBEEF0000, 2, 1, 1, 32'h77777777, 32'hA5A5A5A5, 1, 3);
    step();
    step();
    check("rst_stall_noaccess", 32'(o_stall), 32'd0);
    i_ren = 1'b1;
    #1;
    check("rst_stall_access", 32'(o_stall), 32'd1);
    i_ren = 1'b0; i_rst = 1'b0;
    #1;
    check("rst_rd", o_rd, 32'h0);
    check("rst_req", 32'(o_mem_req), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_addr", o_mem_addr, 32'h0);
    check("rst_wdata", o_mem_wdata, 32'h0);
    check("rst_be", 32'(o_mem_be), 32'd0);
    for (int i = 0; i < 9; i++) run_txn(tbl[i]);
    for (int i = 0; i < 3; i++) begin
      step();
      check("nomem_stall", 32'(o_stall), 32'd0);
      check("nomem_req", 32'(o_mem_req), 32'd0);
    end
    i_ren = 1'b1; i_addr = 32'h500;
    step();
    check("abort_req1", 32'(o_mem_req), 32'd1);
    step();
    check("abort_req2", 32'(o_mem_req), 32'd1);
    i_rst = 1'b1;
    #1;
    check("abort_rst_stall", 32'(o_stall), 32'd1);
    step();
    i_rst = 1'b0; i_ren = 1'b0;
    #1;
    check("abort_req_off", 32'(o_mem_req), 32'd0);
    check("abort_rd", o_rd, 32'h0);
    check("abort_stall", 32'(o_stall), 32'd0);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h13579BDF; i_mem_err = 1'b1;
    step();
    i_mem_ack = 1'b0;
    #1;
    check("stray_req", 32'(o_mem_req), 32'd0);
    check("stray_rd", o_rd, 32'h0);
    check("stray_fault", 32'(o_fault), 32'd0);
    rd_model = 32'h0;
    for (int i = 0; i < 40; i++) begin
      v.wen    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      v.ren    = (v.wen == 4'h0) ? 1'b1 : 1'($urandom);
      v.addr   = $urandom & 32'hFFFFFFFC;
      v.wd     = $urandom;
      v.wait_n = $urandom_range(0, 5);
      v.ack    = $urandom_range(0, 99) < 85;
      v.err    = $urandom_range(0, 99) < 20;
      v.rdata  = $urandom;
      v = model(v, rd_model);
      run_txn(v);
      rd_model = v.exp_rd;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
